// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate enable, scan coordinates, and sync/blank
// signals delayed to line up with the renderer's colour input.
module vga_sync_gen #(
  parameter int CLK_DIV    = 2,
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0,
  parameter int PIPE_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  PIXEL,
  output logic [10:0] PIXEL_H,
  output logic [10:0] PIXEL_V,
  output logic        pixel_tick,
  output logic        video_on,
  output logic        frame_start,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_R,
  output logic        VGA_G,
  output logic        VGA_B
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [2:0]  DIV_LAST = 3'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
  localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
  localparam logic [10:0] HS_BEG   = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_BEG   = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic        HS_ACT   = (HS_POL != 0);
  localparam logic        VS_ACT   = (VS_POL != 0);

  logic [2:0]  r_div_cnt;
  logic        r_tick;
  logic        r_frame_start;
  logic [10:0] r_h;
  logic [10:0] r_v;
  logic        r_hs;
  logic        r_vs;
  logic [2:0]  r_rgb;
  logic        w_h_wrap;
  logic        w_v_wrap;
  logic        w_video_on;
  logic [2:0]  w_raw;   // {hs_active, vs_active, blank}
  logic [2:0]  w_dly;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= 3'd0;
      r_tick    <= 1'b0;
    end else begin
      r_tick <= (r_div_cnt == DIV_LAST);
      if (r_div_cnt == DIV_LAST) begin
        r_div_cnt <= 3'd0;
      end else begin
        r_div_cnt <= r_div_cnt + 3'd1;
      end
    end
  end

  assign w_h_wrap = (r_h == H_LAST);
  assign w_v_wrap = (r_v == V_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h           <= 11'd0;
      r_v           <= 11'd0;
      r_frame_start <= 1'b0;
    end else if (r_tick) begin
      r_frame_start <= w_h_wrap && w_v_wrap;
      if (w_h_wrap) begin
        r_h <= 11'd0;
        r_v <= w_v_wrap ? 11'd0 : (r_v + 11'd1);
      end else begin
        r_h <= r_h + 11'd1;
      end
    end else begin
      r_frame_start <= 1'b0;
    end
  end

  assign w_video_on = (r_h < H_VIS) && (r_v < V_VIS);
  assign w_raw = {(r_h >= HS_BEG) && (r_h < HS_END),
                  (r_v >= VS_BEG) && (r_v < VS_END),
                  ~w_video_on};

  // Reset fills the delay line with blanked, sync-inactive entries so a
  // restart never replays stale timing from the interrupted frame.
  generate
    if (PIPE_DELAY == 0) begin : g_direct
      assign w_dly = w_raw;
    end else begin : g_pipe
      logic [2:0] r_stage [PIPE_DELAY];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < PIPE_DELAY; i++) begin
            r_stage[i] <= 3'b001;
          end
        end else if (r_tick) begin
          r_stage[0] <= w_raw;
          for (int i = 1; i < PIPE_DELAY; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
        end
      end

      assign w_dly = r_stage[PIPE_DELAY-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hs  <= ~HS_ACT;
      r_vs  <= ~VS_ACT;
      r_rgb <= 3'b000;
    end else if (r_tick) begin
      r_hs  <= w_dly[2] ? HS_ACT : ~HS_ACT;
      r_vs  <= w_dly[1] ? VS_ACT : ~VS_ACT;
      r_rgb <= w_dly[0] ? 3'b000 : PIXEL;
    end
  end

  assign PIXEL_H     = r_h;
  assign PIXEL_V     = r_v;
  assign pixel_tick  = r_tick;
  assign video_on    = w_video_on;
  assign frame_start = r_frame_start;
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign {VGA_R, VGA_G, VGA_B} = r_rgb;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Timing-generator and output stage for the text/tile video path.
- Produces the PIXEL_H/PIXEL_V scan coordinates consumed by the text renderers, plus the pixel-rate enable.
- Takes the renderers' 3-bit PIXEL colour back in and drives the VGA connector pins.
- Sync and blank signals are delayed through a programmable pipeline so they stay aligned with the renderer's font-ROM read latency.

Parameters:
- CLK_DIV, 2: system clocks per pixel. Legal range 1..8; 50 MHz / 2 = 25 MHz pixel rate.
- H_DISPLAY, 640: visible pixels per line.
- H_FRONT, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BACK, 48: horizontal back porch, in pixels.
- V_DISPLAY, 480: visible lines per frame.
- V_FRONT, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BACK, 33: vertical back porch, in lines.
- HS_POL, 0: active level of VGA_HS (0 = active-low).
- VS_POL, 0: active level of VGA_VS (0 = active-low).
- PIPE_DELAY, 1: pixel ticks between coordinate output and PIXEL input validity. Legal range 0..4.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- PIXEL  input  3  {R,G,B} colour from the renderer for the coordinate issued PIPE_DELAY ticks earlier
- PIXEL_H  output  11  current horizontal count, 0..H_TOTAL-1
- PIXEL_V  output  11  current vertical count, 0..V_TOTAL-1
- pixel_tick  output  1  one-clk-wide enable, once per pixel
- video_on  output  1  undelayed: high when PIXEL_H<H_DISPLAY and PIXEL_V<V_DISPLAY
- frame_start  output  1  one-clk pulse, high on the tick where the counters wrap to (0,0)
- VGA_HS  output  1  registered horizontal sync
- VGA_VS  output  1  registered vertical sync
- VGA_R  output  1  registered red
- VGA_G  output  1  registered green
- VGA_B  output  1  registered blue

Behaviour:
- Derived constants:
  - H_TOTAL = sum of the four H_* parameters (800).
  - V_TOTAL = sum of the four V_* parameters (525).
- All flops clear asynchronously on reset high.
- Reset values:
  - div counter, PIXEL_H, PIXEL_V = 0.
  - pixel_tick, frame_start = 0.
  - VGA_R/G/B = 0.
  - VGA_HS = ~HS_POL and VGA_VS = ~VS_POL (inactive).
  - Delay pipeline holds the blanked/inactive state.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pixel_tick is registered and high for one clk when div_cnt == CLK_DIV-1.
  - With CLK_DIV=1, pixel_tick is high every clk after the first clk following reset release.
- Counters: update only on a clk edge with pixel_tick=1.
  - PIXEL_H increments and wraps from H_TOTAL-1 to 0.
  - PIXEL_V increments only when PIXEL_H wraps; it wraps from V_TOTAL-1 to 0 when PIXEL_H wraps at the same time.
  - Both counters are registered, 11 bits, and never exceed TOTAL-1.
- frame_start is registered and asserts for the one clk in which PIXEL_H and PIXEL_V both become 0, on that pixel_tick edge.
- Raw timing, combinational from the counters:
  - hs_raw active when H_DISPLAY+H_FRONT <= PIXEL_H < H_DISPLAY+H_FRONT+H_SYNC (656..751).
  - vs_raw active when V_DISPLAY+V_FRONT <= PIXEL_V < V_DISPLAY+V_FRONT+V_SYNC (490..491).
  - blank_raw = ~video_on.
- Delay pipeline:
  - hs_raw, vs_raw and blank_raw pass through a PIPE_DELAY-stage shift register.
  - The register advances only on pixel_tick.
  - PIPE_DELAY=0 means a direct path.
- Output register, loaded on pixel_tick:
  - VGA_HS = delayed hs XNOR HS_POL-encoded level.
  - VGA_VS = delayed vs XNOR VS_POL-encoded level.
  - VGA_R/G/B = PIXEL when delayed blank=0, otherwise 0.
  - PIXEL is sampled only on pixel_tick edges; values in other clks are ignored.
- Total latency from the coordinate change to the pin change is PIPE_DELAY+1 pixel ticks.
- Reset mid-frame: all outputs immediately return to their reset values. On release, scanning restarts at (0,0) with a full frame; no partial-frame sync pulse is emitted from stale pipeline contents.

Test Plan:
- Reset then free-run at defaults for 800*525*2 clks:
  - exactly one frame_start pulse.
  - PIXEL_H takes 0..799; PIXEL_V takes 0..524.
  - pixel_tick high on every 2nd clk.
- Horizontal timing, defaults, PIXEL held at 3'b111:
  - VGA_HS low for exactly 96 ticks, starting 2 ticks after PIXEL_H reaches 656 (PIPE_DELAY=1).
  - VGA_R/G/B high for 640 ticks per visible line, 0 in the remainder.
- Vertical timing:
  - VGA_VS low for exactly 2 lines (1600 ticks), beginning in line 490.
  - RGB stays 0 throughout lines 480..524 even with PIXEL=3'b111.
- Small-parameter run: CLK_DIV=1, H_* = 4/1/2/1, V_* = 3/1/1/1, PIPE_DELAY=0, HS_POL=1.
  - Required: H_TOTAL 8, V_TOTAL 6.
  - VGA_HS high when PIXEL_H was 5..6 one tick earlier.
  - frame_start every 48 clks.
- Alignment: drive PIXEL = 3'b101 only when the coordinate issued PIPE_DELAY ticks earlier was (10,0); otherwise drive 0.
  - Required: exactly one output pixel with R=1, G=0, B=1, appearing on the tick PIPE_DELAY+1 after PIXEL_H=10, PIXEL_V=0.
- Reset asserted at PIXEL_H=700, PIXEL_V=300 for 3 clks (not clock-aligned):
  - outputs go to reset values within the same cycle.
  - after release, the counters restart at 0.
  - the first VGA_VS pulse occurs at line 490 of the new frame.
